// File: rtl/vga_pattern_engine.sv
// Multi-mode VGA pattern source: diagonal, bars, checker and LFSR noise, with a
// frame-stepped animation counter and a one-clock registered RGB/sync output stage.
module vga_pattern_engine #(
    parameter int COLOR_BITS   = 2,
    parameter int COUNTER_BITS = 10,
    parameter int SPEED_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            hpos,
    input  logic [9:0]            vpos,
    input  logic                  display_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [1:0]            mode,
    input  logic [SPEED_BITS-1:0] speed,
    input  logic                  pause,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic                  frame_tick
);

    localparam int          C         = COLOR_BITS;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        PAT_DIAG  = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_NOISE = 2'd3
    } pattern_e;

    pattern_e                mode_q;
    logic [COUNTER_BITS-1:0] counter;
    logic [SPEED_BITS-1:0]   presc;
    logic [15:0]             lfsr;
    logic [15:0]             lfsr_next;
    logic                    vsync_d;
    logic                    fs;
    logic [9:0]              cnt10;
    logic [9:0]              mx;
    logic [8:0]              bx;
    logic                    chk_k;
    logic [C-1:0]            chk_v;
    logic [C-1:0]            pat_r;
    logic [C-1:0]            pat_g;
    logic [C-1:0]            pat_b;

    // Raster arithmetic is always 10 bits wide regardless of the counter width.
    generate
        if (COUNTER_BITS >= 10) begin : g_cnt_trunc
            assign cnt10 = counter[9:0];
        end else begin : g_cnt_ext
            assign cnt10 = {{(10-COUNTER_BITS){1'b0}}, counter};
        end
    endgenerate

    assign fs        = vsync_in & ~vsync_d;
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign mx        = hpos + vpos + cnt10;
    assign bx        = hpos[8:0] + cnt10[8:0];
    assign chk_k     = hpos[4] ^ vpos[4];
    assign chk_v     = counter[COUNTER_BITS-1 -: C];

    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        case (mode_q)
            PAT_DIAG: begin
                pat_r = mx[4 +: C];
                pat_g = mx[5 +: C];
                pat_b = vpos[4 +: C];
            end
            PAT_BARS: begin
                pat_r = {C{bx[6]}};
                pat_g = {C{bx[7]}};
                pat_b = {C{bx[8]}};
            end
            PAT_CHECK: begin
                pat_r = chk_k ? chk_v : ~chk_v;
                pat_g = chk_k ? chk_v : ~chk_v;
                pat_b = chk_k ? chk_v : ~chk_v;
            end
            PAT_NOISE: begin
                pat_r = lfsr[0 +: C];
                pat_g = lfsr[4 +: C];
                pat_b = lfsr[8 +: C];
            end
            default: ;
        endcase
    end

    // vsync_d resets high so a vsync already high at release is not a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d    <= 1'b1;
            mode_q     <= PAT_DIAG;
            counter    <= '0;
            presc      <= '0;
            lfsr       <= LFSR_SEED;
            frame_tick <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
        end else begin
            vsync_d    <= vsync_in;
            frame_tick <= fs;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            r          <= display_on ? pat_r : '0;
            g          <= display_on ? pat_g : '0;
            b          <= display_on ? pat_b : '0;
            if (fs) begin
                mode_q <= pattern_e'(mode);
                lfsr   <= LFSR_SEED;
                if (!pause) begin
                    // >= so a speed lowered below presc still steps on the next frame
                    if (presc >= speed) begin
                        presc   <= '0;
                        counter <= counter + 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            end else if (display_on) begin
                lfsr <= lfsr_next;
            end
        end
    end

endmodule
